// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between CPU fetch and load/store ports.
// Optional wait timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_inst,
  output logic            o_if_valid,
  input  logic            i_d_req,
  input  logic            i_d_write,
  input  logic [XLEN-1:0] i_d_addr,
  input  logic [XLEN-1:0] i_d_wdata,
  input  logic [1:0]      i_d_size,
  output logic [XLEN-1:0] o_d_rdata,
  output logic            o_d_valid,
  output logic            o_stall,
  output logic            o_m_req,
  output logic            o_m_write,
  output logic [XLEN-1:0] o_m_addr,
  output logic [XLEN-1:0] o_m_wdata,
  output logic [1:0]      o_m_size,
  input  logic            i_m_ack,
  input  logic [XLEN-1:0] i_m_rdata,
  output logic            o_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_WAIT = 2'd1;
  localparam logic [1:0] S_D_WAIT  = 2'd2;
  localparam logic [1:0] S_D_SKIP  = 2'd3;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  logic [1:0] state;
  logic       last_grant;
  logic       grant_if;
  logic       grant_d;
  logic       d_skip;
  logic       waiting;
  logic       timeout;
  logic       finish;

  // Round-robin on contention: whichever port did not win last time goes first.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == S_IDLE) begin
      grant_if = i_if_req & (~i_d_req | (last_grant == GRANT_DATA));
      grant_d  = i_d_req  & (~i_if_req | (last_grant == GRANT_FETCH));
    end
  end

  assign d_skip  = i_d_write & (i_d_size == 2'b00);
  assign waiting = (state == S_IF_WAIT) | (state == S_D_WAIT);
  assign finish  = waiting & (i_m_ack | timeout);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires on the TIMEOUT-th consecutive un-acked wait cycle; an ack in that cycle wins.
  assign timeout = waiting & ~i_m_ack & (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt <= '0;
    end else if (!waiting) begin
      wait_cnt <= '0;
    end else if (!i_m_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign o_err      = timeout;
  assign o_if_valid = (state == S_IF_WAIT) & (i_m_ack | timeout);
  assign o_d_valid  = ((state == S_D_WAIT) & (i_m_ack | timeout)) | (state == S_D_SKIP);
  assign o_inst     = timeout ? '0 : i_m_rdata;
  assign o_d_rdata  = ((state == S_D_SKIP) | timeout) ? '0 : i_m_rdata;
  assign o_stall    = (i_if_req & ~o_if_valid) | (i_d_req & ~o_d_valid);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      last_grant <= GRANT_FETCH;
      o_m_req    <= 1'b0;
      o_m_write  <= 1'b0;
      o_m_addr   <= '0;
      o_m_wdata  <= '0;
      o_m_size   <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_if) begin
            last_grant <= GRANT_FETCH;
            o_m_req    <= 1'b1;
            o_m_write  <= 1'b0;
            o_m_addr   <= i_pc;
            o_m_size   <= 2'b11;
            state      <= S_IF_WAIT;
          end else if (grant_d) begin
            last_grant <= GRANT_DATA;
            if (d_skip) begin
              state <= S_D_SKIP;
            end else begin
              o_m_req   <= 1'b1;
              o_m_write <= i_d_write;
              o_m_addr  <= i_d_addr;
              o_m_wdata <= i_d_wdata;
              o_m_size  <= (i_d_size == 2'b00) ? 2'b11 : i_d_size;
              state     <= S_D_WAIT;
            end
          end
        end
        S_IF_WAIT, S_D_WAIT: begin
          if (finish) begin
            o_m_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_D_SKIP: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single-port transactions plus
// contention, reset and timeout sequences, checked through a scoreboard queue.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_pc;
  logic [31:0] o_inst;
  logic        o_if_valid;
  logic        i_d_req;
  logic        i_d_write;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [1:0]  i_d_size;
  logic [31:0] o_d_rdata;
  logic        o_d_valid;
  logic        o_stall;
  logic        o_m_req;
  logic        o_m_write;
  logic [31:0] o_m_addr;
  logic [31:0] o_m_wdata;
  logic [1:0]  o_m_size;
  logic        i_m_ack;
  logic [31:0] i_m_rdata;
  logic        o_err;

  mem_arbiter #(.XLEN(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_pc(i_pc), .o_inst(o_inst), .o_if_valid(o_if_valid),
    .i_d_req(i_d_req), .i_d_write(i_d_write), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_size(i_d_size), .o_d_rdata(o_d_rdata),
    .o_d_valid(o_d_valid), .o_stall(o_stall),
    .o_m_req(o_m_req), .o_m_write(o_m_write), .o_m_addr(o_m_addr),
    .o_m_wdata(o_m_wdata), .o_m_size(o_m_size), .i_m_ack(i_m_ack),
    .i_m_rdata(i_m_rdata), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          ack_cyc;
    logic [31:0] rdata;
    bit          skip;
    logic [1:0]  exp_size;
    logic [31:0] exp_rdata;
  } txn_t;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input bit is_data, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input int ack_cyc, input logic [31:0] rdata, input bit skip,
                              input logic [1:0] exp_size, input logic [31:0] exp_rdata);
    txn_t t;
    t.is_data = is_data; t.wr = wr; t.addr = addr; t.wdata = wdata; t.size = size;
    t.ack_cyc = ack_cyc; t.rdata = rdata; t.skip = skip;
    t.exp_size = exp_size; t.exp_rdata = exp_rdata;
    return t;
  endfunction

  task automatic sb_push(input bit is_data, input logic [31:0] data);
    sb_t e;
    e.is_data = is_data;
    e.data    = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input bit got_data, input logic [31:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected: got valid with data 0x%0h required no valid", got);
    end else begin
      e = sb_q.pop_front();
      chk("sb_port", 32'(got_data), 32'(e.is_data));
      chk("sb_data", got, e.data);
    end
  endtask

  task automatic idle_inputs();
    i_if_req = 1'b0; i_pc = '0;
    i_d_req = 1'b0; i_d_write = 1'b0; i_d_addr = '0; i_d_wdata = '0; i_d_size = 2'b00;
    i_m_ack = 1'b0; i_m_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    idle_inputs();
    i_rst = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic run_txn(input txn_t t);
    int  held;
    bit  done;
    held = 0;
    done = 0;
    @(negedge i_clk);
    if (t.is_data) begin
      i_d_req = 1'b1; i_d_write = t.wr; i_d_addr = t.addr;
      i_d_wdata = t.wdata; i_d_size = t.size;
    end else begin
      i_if_req = 1'b1; i_pc = t.addr;
    end
    sb_push(t.is_data, t.exp_rdata);
    #1;
    chk("stall_on_req", 32'(o_stall), 32'd1);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge i_clk);
      i_m_ack = 1'b0;
      if (c > 0) begin
        i_pc = ~t.addr; i_d_addr = ~t.addr; i_d_wdata = ~t.wdata;
      end
      if (o_m_req) begin
        if (held == 0) begin
          chk("m_addr", o_m_addr, t.addr);
          chk("m_size", 32'(o_m_size), 32'(t.exp_size));
          chk("m_write", 32'(o_m_write), 32'(t.wr));
          if (t.wr) chk("m_wdata", o_m_wdata, t.wdata);
        end else begin
          chk("m_addr_hold", o_m_addr, t.addr);
        end
        if (held + 1 == t.ack_cyc) begin
          i_m_ack = 1'b1;
          i_m_rdata = t.rdata;
        end
        held++;
      end
      #1;
      if (o_if_valid || o_d_valid) begin
        done = 1;
        sb_check(o_d_valid, o_d_valid ? o_d_rdata : o_inst);
        chk("latency", 32'(c), t.skip ? 32'd0 : 32'(t.ack_cyc - 1));
        chk("req_cycles", 32'(held), t.skip ? 32'd0 : 32'(t.ack_cyc));
        chk("stall_at_valid", 32'(o_stall), 32'd0);
        chk("err_at_valid", 32'(o_err), 32'd0);
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_timeout: got no valid for addr 0x%0h required one", t.addr);
    end
    @(negedge i_clk);
    idle_inputs();
    #1;
    chk("m_req_after", 32'(o_m_req), 32'd0);
  endtask

  txn_t vec[7];

  initial begin
    i_rst = 1'b1;
    idle_inputs();

    vec[0] = mk(0, 0, 32'h0000_0100, 32'h0,          2'b00, 1, 32'h0000_0013, 0, 2'b11, 32'h0000_0013);
    vec[1] = mk(1, 1, 32'h0000_2003, 32'h0000_00AB, 2'b01, 3, 32'hDEAD_BEEF, 0, 2'b01, 32'hDEAD_BEEF);
    vec[2] = mk(1, 0, 32'h0000_3000, 32'h0,          2'b00, 2, 32'h1234_5678, 0, 2'b11, 32'h1234_5678);
    vec[3] = mk(1, 0, 32'h0000_4002, 32'h0,          2'b10, 1, 32'h0000_CAFE, 0, 2'b10, 32'h0000_CAFE);
    vec[4] = mk(1, 1, 32'h0000_4100, 32'h5555_5555, 2'b00, 1, 32'hFFFF_FFFF, 1, 2'b00, 32'h0000_0000);
    vec[5] = mk(1, 1, 32'h0000_5000, 32'h1122_3344, 2'b11, 2, 32'h0BAD_F00D, 0, 2'b11, 32'h0BAD_F00D);
    vec[6] = mk(0, 0, 32'h0000_0104, 32'h0,          2'b00, 4, 32'h8765_4321, 0, 2'b11, 32'h8765_4321);

    do_reset();
    #1;
    chk("rst_m_req", 32'(o_m_req), 32'd0);
    chk("rst_m_write", 32'(o_m_write), 32'd0);
    chk("rst_m_addr", o_m_addr, 32'd0);
    chk("rst_m_wdata", o_m_wdata, 32'd0);
    chk("rst_m_size", 32'(o_m_size), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_valids", 32'({o_if_valid, o_d_valid}), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);

    for (int i = 0; i < 7; i++) run_txn(vec[i]);

    // Contention from reset with both requests held: expect D, F, D, F.
    do_reset();
    sb_push(1, 32'h5A5A_0600);
    sb_push(0, 32'h5A5A_0200);
    sb_push(1, 32'h5A5A_0600);
    sb_push(0, 32'h5A5A_0200);
    begin
      int got;
      got = 0;
      @(negedge i_clk);
      i_if_req = 1'b1; i_pc = 32'h0000_0200;
      i_d_req = 1'b1; i_d_write = 1'b0; i_d_addr = 32'h0000_0600; i_d_size = 2'b11;
      for (int c = 0; c < 60 && got < 4; c++) begin
        @(negedge i_clk);
        i_m_ack = 1'b0;
        if (o_m_req) begin
          i_m_ack = 1'b1;
          i_m_rdata = o_m_addr ^ 32'h5A5A_0000;
        end
        #1;
        if (o_if_valid || o_d_valid) begin
          sb_check(o_d_valid, o_d_valid ? o_d_rdata : o_inst);
          got++;
        end
      end
      @(negedge i_clk);
      idle_inputs();
      chk("contention_count", 32'(got), 32'd4);
    end

    // Reset in the middle of a load: the transaction is dropped silently.
    @(negedge i_clk);
    i_d_req = 1'b1; i_d_write = 1'b0; i_d_addr = 32'h0000_0700; i_d_size = 2'b11;
    @(negedge i_clk);
    #1;
    chk("rst_mid_req_up", 32'(o_m_req), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_d_req = 1'b0;
    #1;
    chk("rst_mid_req_down", 32'(o_m_req), 32'd0);
    i_m_ack = 1'b1;
    i_m_rdata = 32'h7777_7777;
    #1;
    chk("rst_mid_no_dvalid", 32'(o_d_valid), 32'd0);
    chk("rst_mid_no_ifvalid", 32'(o_if_valid), 32'd0);
    @(negedge i_clk);
    i_m_ack = 1'b0;
    #1;
    chk("rst_mid_idle", 32'(o_m_req), 32'd0);
    run_txn(mk(0, 0, 32'h0000_0800, 32'h0, 2'b00, 2, 32'h0000_0A0A, 0, 2'b11, 32'h0000_0A0A));

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      bit seen;
      seen = 0;
      @(negedge i_clk);
      i_if_req = 1'b1; i_pc = 32'h0000_0900; i_m_rdata = 32'hFFFF_FFFF;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge i_clk);
        #1;
        if (o_if_valid) begin
          seen = 1;
          chk("to_err", 32'(o_err), 32'd1);
          chk("to_inst", o_inst, 32'd0);
          chk("to_cycle", 32'(c), 32'd3);
        end
      end
      chk("to_seen", 32'(seen), 32'd1);
      @(negedge i_clk);
      idle_inputs();
      #1;
      chk("to_req_down", 32'(o_m_req), 32'd0);
    end
    run_txn(mk(0, 0, 32'h0000_0904, 32'h0, 2'b00, 4, 32'h0000_4444, 0, 2'b11, 32'h0000_4444));
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
